imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of the immediate extender: takes a 32-bit constant and emits the 16-bit immediate beat(s) plus EOp select that the extender maps back to that constant.
- Used by the instruction-generation and test-program path to materialise constants.
- A constant that no single extender mode can reach is split into a two-beat lui/ori pair: upper half with EOp=10, then lower half with EOp=01, ORed by the consumer.
- Valid/ready on both sides. FSM-sequenced, one constant in flight.

Parameters:
- EN_SHIFT, 1, when 1 the EOp=11 form (sext(imm)<<2) is a candidate encoding; when 0 it is never emitted.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock and a synchronous active-high reset, nothing else
- in_valid  input  1  in_data holds a constant to encode
- in_ready  output  1  block can accept a constant this cycle
- in_data  input  32  constant to encode
- out_valid  output  1  out_imm/out_eop/out_last hold a valid beat
- out_ready  input  1  consumer takes the beat this cycle
- out_imm  output  16  immediate field of the beat
- out_eop  output  2  extender mode: 00 sign, 01 zero, 10 upper (lui), 11 sign<<2
- out_last  output  1  1 on the final beat of a constant

Behaviour:
- States:
  - IDLE: in_ready=1, out_valid=0.
  - ONE: single-beat result pending, out_last=1.
  - HI: first beat of a pair pending, out_last=0.
  - LO: second beat of a pair pending, out_last=1.
- Reset values: state=IDLE; out_valid=0; out_imm=16'h0000; out_eop=2'b00; out_last=0. in_ready=1 in the first cycle after reset is released.
- Accept: in_valid && in_ready at edge k. The constant is classified and registered, and out_valid=1 from cycle k+1. Latency is 1 cycle to the first beat.
- Classification priority, first match wins, with v=in_data:
  1. sign: v[31:15] all equal -> imm=v[15:0], eop=00.
  2. zero: v[31:16]==0 -> imm=v[15:0], eop=01.
  3. lui: v[15:0]==0 -> imm=v[31:16], eop=10.
  4. shift (only if EN_SHIFT): v[1:0]==0 and v[31:17] all equal -> imm=v[17:2], eop=11.
  5. Otherwise a pair: HI beat imm=v[31:16], eop=10; LO beat imm=v[15:0], eop=01.
- Transitions:
  - IDLE->ONE or IDLE->HI on accept.
  - ONE->IDLE on out handshake.
  - HI->LO on out handshake. The lower half is held in an internal register captured at accept.
  - LO->IDLE on out handshake.
- in_ready=1 only in IDLE; no accept is possible in the cycle of the final handshake. Peak throughput is one single-beat constant per 2 cycles, or one pair per 3 cycles.
- Backpressure: while out_valid && !out_ready, out_imm, out_eop and out_last hold stable and the state does not advance.
- in_data is sampled only on accept. Changes at any other time are ignored.
- reset asserted in any state, including mid-pair: next cycle is IDLE with the reset output values. The pending lower half is discarded.
- Round-trip invariant: feeding every beat through the extender (OR-ing the pair) reproduces in_data exactly.

Decomposition:
- Shared package holds:
  - EOp constants EOP_SEXT=2'b00, EOP_ZEXT=2'b01, EOP_LUI=2'b10, EOP_SHL2=2'b11, identical to those the extender decodes.
  - State encoding S_IDLE, S_ONE, S_HI, S_LO.
- Sub-module imm_classify: purely combinational in_data -> {pair, imm, eop} per the priority list above, with EN_SHIFT passed through.
- The FSM, holding registers and handshake stay in imm_encoder.

Test Plan:
- in 32'hFFFF_8000, out_ready=1 -> one beat: imm 16'h8000, eop 00, last 1; in_ready high again the cycle after the handshake.
- in 32'h0000_8000 -> one beat: imm 16'h8000, eop 01, last 1. Then in 32'h1234_0000 -> one beat: imm 16'h1234, eop 10, last 1.
- in 32'h0001_FFFC:
  - EN_SHIFT=1 -> one beat: imm 16'h7FFF, eop 11, last 1.
  - EN_SHIFT=0 -> two beats: (16'h0001, 10, last 0) then (16'hFFFC, 01, last 1).
- in 32'h1234_5678 -> (16'h1234, 10, last 0) then (16'h5678, 01, last 1); in_ready=0 throughout and in_valid is ignored meanwhile.
- 32'h1234_5678 with out_ready=0 for 3 cycles on the HI beat -> HI beat held unchanged for all 3 cycles; LO beat appears the cycle after out_ready rises.
- reset pulsed while the LO beat is pending -> next cycle out_valid=0, out_imm=0, in_ready=1. A following in 32'h0000_0005 yields imm 16'h0005, eop 00, last 1.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// imm_encoder_pkg: extender mode codes and encoder FSM state encoding
package imm_encoder_pkg;
    localparam logic [1:0] EOP_SEXT = 2'b00;
    localparam logic [1:0] EOP_ZEXT = 2'b01;
    localparam logic [1:0] EOP_LUI  = 2'b10;
    localparam logic [1:0] EOP_SHL2 = 2'b11;
    typedef enum logic [1:0] {S_IDLE, S_ONE, S_HI, S_LO} state_t;
endpackage

// File: rtl/imm_encoder_if.sv
// imm_encoder_if: constant-in / immediate-beat-out valid/ready bundle
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_imm;
    logic [1:0]  out_eop;
    logic        out_last;
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_imm, out_eop, out_last);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_imm, out_eop, out_last);
endinterface

// File: rtl/imm_encoder_classify.sv
// imm_classify: picks the first extender mode that reproduces v, else flags a lui/ori pair
module imm_classify
    import imm_encoder_pkg::*;
#(
    parameter bit EN_SHIFT = 1'b1
) (
    input  logic [31:0] v,
    output logic        pair,
    output logic [15:0] imm,
    output logic [1:0]  eop
);
    logic sgn, zro, lui, shl;
    assign sgn = &v[31:15] | ~|v[31:15];
    assign zro = ~|v[31:16];
    assign lui = ~|v[15:0];
    assign shl = EN_SHIFT && ~|v[1:0] && (&v[31:17] | ~|v[31:17]);
    // The pair case shares the lui encoding for its first beat
    always_comb begin
        pair = !(sgn || zro || lui || shl);
        imm  = (sgn || zro) ? v[15:0] : shl && !lui ? v[17:2] : v[31:16];
        eop  = sgn ? EOP_SEXT : zro ? EOP_ZEXT : lui ? EOP_LUI : shl ? EOP_SHL2 : EOP_LUI;
    end
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: emits the immediate beat(s) and EOp that an extender maps back to a 32-bit constant
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter bit EN_SHIFT = 1'b1
) (
    input logic         clk,
    input logic         reset,
    imm_encoder_if.slave bus
);
    state_t      state;
    logic [15:0] lo;
    logic        c_pair;
    logic [15:0] c_imm;
    logic [1:0]  c_eop;

    imm_classify #(.EN_SHIFT(EN_SHIFT)) u_cls (
        .v    (bus.in_data),
        .pair (c_pair),
        .imm  (c_imm),
        .eop  (c_eop)
    );

    assign bus.in_ready  = state == S_IDLE;
    assign bus.out_valid = state != S_IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            lo           <= 16'h0000;
            bus.out_imm  <= 16'h0000;
            bus.out_eop  <= EOP_SEXT;
            bus.out_last <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.in_valid) begin
                    state        <= c_pair ? S_HI : S_ONE;
                    lo           <= bus.in_data[15:0];
                    bus.out_imm  <= c_imm;
                    bus.out_eop  <= c_eop;
                    bus.out_last <= !c_pair;
                end
                S_ONE: if (bus.out_ready) state <= S_IDLE;
                S_HI: if (bus.out_ready) begin
                    state        <= S_LO;
                    bus.out_imm  <= lo;
                    bus.out_eop  <= EOP_ZEXT;
                    bus.out_last <= 1'b1;
                end
                S_LO: if (bus.out_ready) state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed vectors against both EN_SHIFT builds plus backpressure and reset corners
module tb_imm_encoder;
    logic        clk, reset, sel, iv, oready;
    logic [31:0] din;
    logic        ov, ir, ol;
    logic [15:0] oi;
    logic [1:0]  oe;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        bit          d;
        logic [31:0] v;
        bit          two;
        logic [15:0] i0;
        logic [1:0]  e0;
        logic [15:0] i1;
    } vec_t;
    vec_t tv[14];

    imm_encoder_if b1();
    imm_encoder_if b0();

    imm_encoder #(.EN_SHIFT(1'b1)) u1 (.clk(clk), .reset(reset), .bus(b1));
    imm_encoder #(.EN_SHIFT(1'b0)) u0 (.clk(clk), .reset(reset), .bus(b0));

    assign b1.in_valid  = sel & iv;
    assign b0.in_valid  = !sel & iv;
    assign b1.in_data   = din;
    assign b0.in_data   = din;
    assign b1.out_ready = oready;
    assign b0.out_ready = oready;
    assign ov = sel ? b1.out_valid : b0.out_valid;
    assign ir = sel ? b1.in_ready  : b0.in_ready;
    assign oi = sel ? b1.out_imm   : b0.out_imm;
    assign oe = sel ? b1.out_eop   : b0.out_eop;
    assign ol = sel ? b1.out_last  : b0.out_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic beat(input string nm, input logic [15:0] i, input logic [1:0] e, input logic l);
        chk({nm, "_valid"}, {31'd0, ov}, 32'd1);
        chk({nm, "_imm"}, {16'd0, oi}, {16'd0, i});
        chk({nm, "_eop"}, {30'd0, oe}, {30'd0, e});
        chk({nm, "_last"}, {31'd0, ol}, {31'd0, l});
        chk({nm, "_in_ready"}, {31'd0, ir}, 32'd0);
    endtask

    task automatic xfer(input vec_t t);
        @(negedge clk);
        sel = t.d; oready = 1'b1;
        #1;
        chk("in_ready_idle", {31'd0, ir}, 32'd1);
        iv = 1'b1; din = t.v;
        @(negedge clk);
        din = 32'hA5A5_A5A5;
        iv = t.two;
        beat("first", t.i0, t.e0, !t.two);
        if (t.two) begin
            @(negedge clk);
            iv = 1'b0;
            beat("lo", t.i1, 2'b01, 1'b1);
        end
        @(negedge clk);
        chk("idle_valid", {31'd0, ov}, 32'd0);
        chk("idle_in_ready", {31'd0, ir}, 32'd1);
    endtask

    initial begin
        tv[0]  = '{1'b1, 32'hFFFF_8000, 1'b0, 16'h8000, 2'b00, 16'h0000};
        tv[1]  = '{1'b1, 32'h0000_8000, 1'b0, 16'h8000, 2'b01, 16'h0000};
        tv[2]  = '{1'b1, 32'h1234_0000, 1'b0, 16'h1234, 2'b10, 16'h0000};
        tv[3]  = '{1'b1, 32'h0001_FFFC, 1'b0, 16'h7FFF, 2'b11, 16'h0000};
        tv[4]  = '{1'b0, 32'h0001_FFFC, 1'b1, 16'h0001, 2'b10, 16'hFFFC};
        tv[5]  = '{1'b1, 32'h1234_5678, 1'b1, 16'h1234, 2'b10, 16'h5678};
        tv[6]  = '{1'b0, 32'hFFFF_FFFF, 1'b0, 16'hFFFF, 2'b00, 16'h0000};
        tv[7]  = '{1'b0, 32'h0000_0000, 1'b0, 16'h0000, 2'b00, 16'h0000};
        tv[8]  = '{1'b1, 32'h8000_0000, 1'b0, 16'h8000, 2'b10, 16'h0000};
        tv[9]  = '{1'b1, 32'hFFFE_0000, 1'b0, 16'hFFFE, 2'b10, 16'h0000};
        tv[10] = '{1'b1, 32'hFFFE_0004, 1'b0, 16'h8001, 2'b11, 16'h0000};
        tv[11] = '{1'b0, 32'hFFFE_0004, 1'b1, 16'hFFFE, 2'b10, 16'h0004};
        tv[12] = '{1'b1, 32'h0000_FFFF, 1'b0, 16'hFFFF, 2'b01, 16'h0000};
        tv[13] = '{1'b0, 32'h7FFF_8001, 1'b1, 16'h7FFF, 2'b10, 16'h8001};

        reset = 1'b1; iv = 1'b0; oready = 1'b0; sel = 1'b1; din = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_valid1", {31'd0, b1.out_valid}, 32'd0);
        chk("rst_ready1", {31'd0, b1.in_ready}, 32'd1);
        chk("rst_imm1", {16'd0, b1.out_imm}, 32'd0);
        chk("rst_eop1", {30'd0, b1.out_eop}, 32'd0);
        chk("rst_last1", {31'd0, b1.out_last}, 32'd0);
        chk("rst_valid0", {31'd0, b0.out_valid}, 32'd0);
        chk("rst_ready0", {31'd0, b0.in_ready}, 32'd1);

        for (int i = 0; i < 14; i++) xfer(tv[i]);

        // HI beat stalled for three cycles
        @(negedge clk);
        sel = 1'b1; #1;
        iv = 1'b1; din = 32'h1234_5678; oready = 1'b0;
        @(negedge clk);
        iv = 1'b0; din = 32'h0;
        for (int k = 0; k < 3; k++) begin
            beat("stall_hi", 16'h1234, 2'b10, 1'b0);
            if (k < 2) @(negedge clk);
        end
        oready = 1'b1;
        @(negedge clk);
        beat("stall_lo", 16'h5678, 2'b01, 1'b1);
        @(negedge clk);
        chk("stall_idle", {31'd0, ov}, 32'd0);

        // reset while the LO beat is pending
        @(negedge clk);
        iv = 1'b1; din = 32'h1234_5678; oready = 1'b1;
        @(negedge clk);
        iv = 1'b0;
        beat("rp_hi", 16'h1234, 2'b10, 1'b0);
        @(negedge clk);
        beat("rp_lo", 16'h5678, 2'b01, 1'b1);
        oready = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rp_valid", {31'd0, ov}, 32'd0);
        chk("rp_imm", {16'd0, oi}, 32'd0);
        chk("rp_eop", {30'd0, oe}, 32'd0);
        chk("rp_last", {31'd0, ol}, 32'd0);
        chk("rp_in_ready", {31'd0, ir}, 32'd1);
        xfer('{1'b1, 32'h0000_0005, 1'b0, 16'h0005, 2'b00, 16'h0000});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
